blkram_arbiter: RTL

- Two-master arbiter for the shared block RAM: master 0 (CPU bus) and master 1 (DMA / boot loader).
- Accepts valid/ready requests, grants one at a time and drives the RAM's select/we/rd/addr/data_in ports from registers.
- Captures the RAM's registered read data and returns it to the granted master.
- Out-of-range addresses are rejected with an error acknowledge and never reach the RAM.

---
 rtl/blkram_arbiter_if.sv | 46 ++++
 rtl/blkram_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/blkram_arbiter_if.sv
// Request/response bundle between the two RAM masters, the arbiter and the block RAM.
// The slave modport is the arbiter's view; the master modport is the masters-plus-RAM side.
interface blkram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              m0_valid;
  logic [3:0]        m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [31:0]       m0_rdata;
  logic              m0_ready;
  logic              m0_err;

  logic              m1_valid;
  logic [3:0]        m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [31:0]       m1_rdata;
  logic              m1_ready;
  logic              m1_err;

  logic              ram_select;
  logic [3:0]        ram_we;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  m0_valid, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ready, m0_err,
    input  m1_valid, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ready, m1_err,
    output ram_select, ram_we, ram_rd, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_valid, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready, m0_err,
    output m1_valid, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready, m1_err,
    input  ram_select, ram_we, ram_rd, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/blkram_arbiter.sv
// Two-master arbiter for the shared block RAM with out-of-range rejection.
// Define BLKRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (master 0 first).
//
// state  | meaning
// IDLE   | no access in flight; arbitrate between requesters
// ISSUE  | registered ram_* outputs presented; RAM samples at end of cycle
// RESP   | ready/err/rdata to granted master; re-arbitrate with it masked
module blkram_arbiter #(
  parameter int NUM_BLKRAM = 14,
  parameter int ADDR_W     = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  blkram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(128 * NUM_BLKRAM);

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic              err_q;
  logic              rd_q;

  logic              req0;
  logic              req1;
  logic              win;
  logic              do_grant;
  logic [3:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_oor;
  logic              resp0;
  logic              resp1;

  // The master being acknowledged in RESP still holds valid, so it is masked.
  always_comb begin
    req0     = bus.m0_valid && !(state == S_RESP && grant == 1'b0);
    req1     = bus.m1_valid && !(state == S_RESP && grant == 1'b1);
    do_grant = (state == S_IDLE || state == S_RESP) && (req0 || req1);
`ifdef BLKRAM_ARB_RR_EN
    win = (req0 && req1) ? !last_grant : (req1 ? 1'b1 : (req0 ? 1'b0 : last_grant));
`else
    win = req0 ? 1'b0 : (req1 ? 1'b1 : last_grant);
`endif
    sel_we    = win ? bus.m1_we    : bus.m0_we;
    sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    sel_oor   = {1'b0, sel_addr} >= ADDR_LIMIT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      err_q          <= 1'b0;
      rd_q           <= 1'b0;
      bus.ram_select <= 1'b0;
      bus.ram_we     <= 4'd0;
      bus.ram_rd     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= 32'd0;
    end else begin
      bus.ram_select <= 1'b0;
      bus.ram_we     <= 4'd0;
      bus.ram_rd     <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (do_grant) begin
            grant      <= win;
            last_grant <= win;
            err_q      <= sel_oor;
            rd_q       <= (sel_we == 4'd0);
            if (sel_oor) begin
              bus.ram_addr  <= '0;
              bus.ram_wdata <= 32'd0;
              state         <= S_RESP;
            end else begin
              bus.ram_select <= 1'b1;
              bus.ram_rd     <= (sel_we == 4'd0);
              bus.ram_we     <= sel_we;
              bus.ram_addr   <= sel_addr;
              bus.ram_wdata  <= sel_wdata;
              state          <= S_ISSUE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Responses decode straight from state so they vanish the instant reset asserts.
  assign resp0 = (state == S_RESP) && (grant == 1'b0);
  assign resp1 = (state == S_RESP) && (grant == 1'b1);

  assign bus.m0_ready = resp0;
  assign bus.m0_err   = resp0 && err_q;
  assign bus.m0_rdata = (resp0 && rd_q && !err_q) ? bus.ram_rdata : 32'd0;
  assign bus.m1_ready = resp1;
  assign bus.m1_err   = resp1 && err_q;
  assign bus.m1_rdata = (resp1 && rd_q && !err_q) ? bus.ram_rdata : 32'd0;

endmodule
